pwm_fade: RTL and testbench

//  Memory-mapped duty-cycle ramp engine that sits directly upstream of pwm.

---
 rtl/pwm_fade_pkg.sv | 21 ++
 rtl/pwm_fade_tick_gen.sv | 38 +++
 rtl/pwm_fade.sv | 123 ++++++++++++
 tb/tb_pwm_fade.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_fade_pkg.sv
// Shared definitions for the pwm_fade duty-ramp engine: register map,
// clamp/divider defaults and FSM state encoding.
package pwm_fade_pkg;

  localparam logic [1:0] ADDR_TARGET  = 2'd0;
  localparam logic [1:0] ADDR_RATE    = 2'd1;
  localparam logic [1:0] ADDR_CURRENT = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int unsigned MAX_DUTY_DEFAULT = 100;
  localparam int unsigned TICK_DIV_DEFAULT = 1111;
  localparam int unsigned DUTY_W           = 7;
  localparam int unsigned RATE_W           = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_STEP = 2'd2
  } state_t;

endpackage

// File: rtl/pwm_fade_tick_gen.sv
// Base-tick prescaler: counts 0..TICK_DIV-1 while enabled, pulses tick on wrap,
// synchronous clear returns the count to zero.
module pwm_fade_tick_gen #(
  parameter int unsigned TICK_DIV = 1111
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int unsigned   CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] pre_q, pre_d;

  always_comb begin
    pre_d = pre_q;
    tick  = 1'b0;
    if (clr) begin
      pre_d = '0;
    end else if (en) begin
      if (pre_q == LAST) begin
        pre_d = '0;
        tick  = 1'b1;
      end else begin
        pre_d = pre_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pre_q <= '0;
    else     pre_q <= pre_d;
  end

endmodule

// File: rtl/pwm_fade.sv
// Memory-mapped duty ramp engine: walks current duty toward a software target
// one percent per step and drives the downstream pwm write port.
module pwm_fade
  import pwm_fade_pkg::*;
#(
  parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT,
  parameter int unsigned MAX_DUTY = MAX_DUTY_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ADDR,
  input  logic [31:0] WD,
  input  logic        WE,
  output logic [31:0] RD,
  output logic [6:0]  duty_out,
  output logic        duty_we,
  output logic        busy
);

  localparam logic [DUTY_W-1:0] MAX_D = DUTY_W'(MAX_DUTY);

  state_t              state_q, state_d;
  logic [DUTY_W-1:0]   target_q, target_d;
  logic [DUTY_W-1:0]   current_q, current_d;
  logic [RATE_W-1:0]   rate_q, rate_d;
  logic [RATE_W-1:0]   cnt_q, cnt_d;
  logic                duty_we_q, duty_we_d;
  logic                tick;
  logic                wd_unused;

  assign wd_unused = ^WD[31:16];

  // Prescaler only runs in WAIT; held cleared otherwise so each WAIT starts at 0.
  pwm_fade_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (state_q != ST_WAIT),
    .en   (state_q == ST_WAIT),
    .tick (tick)
  );

  always_comb begin
    target_d  = target_q;
    rate_d    = rate_q;
    state_d   = state_q;
    current_d = current_q;
    cnt_d     = cnt_q;
    duty_we_d = 1'b0;

    if (WE && ADDR == ADDR_TARGET)
      target_d = (WD[DUTY_W-1:0] > MAX_D) ? MAX_D : WD[DUTY_W-1:0];
    if (WE && ADDR == ADDR_RATE)
      rate_d = WD[RATE_W-1:0];

    // FSM decisions use target_q, so a write landing with STEP sees the old target.
    case (state_q)
      ST_IDLE: begin
        if (target_q != current_q) begin
          if (rate_q == '0) begin
            current_d = target_q;
            duty_we_d = 1'b1;
          end else begin
            cnt_d   = rate_q;
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (tick) begin
          cnt_d = cnt_q - RATE_W'(1);
          if (cnt_q == RATE_W'(1)) state_d = ST_STEP;
        end
      end
      ST_STEP: begin
        if (target_q > current_q) begin
          current_d = current_q + DUTY_W'(1);
          duty_we_d = 1'b1;
        end else if (target_q < current_q) begin
          current_d = current_q - DUTY_W'(1);
          duty_we_d = 1'b1;
        end
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      target_q  <= '0;
      rate_q    <= '0;
      current_q <= '0;
      cnt_q     <= '0;
      duty_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      rate_q    <= rate_d;
      current_q <= current_d;
      cnt_q     <= cnt_d;
      duty_we_q <= duty_we_d;
    end
  end

  assign duty_out = current_q;
  assign duty_we  = duty_we_q;
  assign busy     = (state_q != ST_IDLE) || (target_q != current_q);

  always_comb begin
    RD = '0;
    case (ADDR)
      ADDR_TARGET:  RD = 32'(target_q);
      ADDR_RATE:    RD = 32'(rate_q);
      ADDR_CURRENT: RD = 32'(current_q);
      ADDR_STATUS:  RD = {31'b0, busy};
      default:      RD = '0;
    endcase
  end

endmodule

// File: tb/tb_pwm_fade.sv
// Bench for pwm_fade with TICK_DIV=4: duty_we pulses are matched against a
// queue of (cycle, duty) expectations pushed by each scenario.
module tb_pwm_fade;

  localparam int TICK = 4;

  logic        clk;
  logic        rst;
  logic [1:0]  ADDR;
  logic [31:0] WD;
  logic        WE;
  logic [31:0] RD;
  logic [6:0]  duty_out;
  logic        duty_we;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  typedef struct {
    int         at;
    logic [6:0] duty;
  } exp_t;

  exp_t exp_q[$];

  pwm_fade #(
    .TICK_DIV (TICK),
    .MAX_DUTY (100)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .ADDR     (ADDR),
    .WD       (WD),
    .WE       (WE),
    .RD       (RD),
    .duty_out (duty_out),
    .duty_we  (duty_we),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Every duty_we pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (duty_we === 1'b1) begin
      vectors = vectors + 1;
      if (exp_q.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL unexpected_pulse: duty_we at cycle %0d duty_out=%0d, required no pulse", cyc, duty_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (duty_out !== e.duty || cyc != e.at) begin
          miscompares = miscompares + 1;
          $display("FAIL pulse: got duty %0d at cycle %0d, required duty %0d at cycle %0d",
                   duty_out, cyc, e.duty, e.at);
        end
      end
    end
  end

  // Caller is at a negedge; returns the cycle number of the capturing edge.
  task automatic write_reg(input logic [1:0] a, input logic [31:0] d, output int ecap);
    ADDR = a;
    WD   = d;
    WE   = 1'b1;
    @(posedge clk);
    @(negedge clk);
    WE   = 1'b0;
    ecap = cyc;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_exp(input int at, input int duty);
    exp_t e;
    e.at   = at;
    e.duty = 7'(duty);
    exp_q.push_back(e);
  endtask

  task automatic test_reset;
    for (int a = 0; a < 4; a++) begin
      ADDR = 2'(a);
      #1;
      vectors = vectors + 1;
      if (RD !== 32'd0) begin
        miscompares = miscompares + 1;
        $display("FAIL reset_rd%0d: got %0d, required 0", a, RD);
      end
    end
    vectors = vectors + 3;
    if (duty_out !== 7'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_duty_out: got %0d, required 0", duty_out);
    end
    if (duty_we !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_duty_we: got %0b, required 0", duty_we);
    end
    if (busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reset_busy: got %0b, required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_jump;
    int e;
    write_reg(2'd0, 32'd60, e);
    push_exp(e + 1, 60);
    wait_until(e + 3);
    ADDR = 2'd2;
    #1;
    vectors = vectors + 3;
    if (duty_out !== 7'd60) begin
      miscompares = miscompares + 1;
      $display("FAIL jump_duty: got %0d, required 60", duty_out);
    end
    if (RD !== 32'd60) begin
      miscompares = miscompares + 1;
      $display("FAIL jump_current_rd: got %0d, required 60", RD);
    end
    if (busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL jump_busy: got %0b, required 0", busy);
    end
    @(negedge clk);
    write_reg(2'd0, 32'd0, e);
    push_exp(e + 1, 0);
    wait_until(e + 3);
  endtask

  task automatic test_ramp_rate2;
    int e;
    write_reg(2'd1, 32'd2, e);
    write_reg(2'd0, 32'd3, e);
    for (int k = 1; k <= 3; k++) push_exp(e + k * (2 * TICK + 2), k);
    wait_until(e + 5);
    vectors = vectors + 1;
    if (busy !== 1'b1) begin
      miscompares = miscompares + 1;
      $display("FAIL ramp2_busy_mid: got %0b, required 1", busy);
    end
    wait_until(e + 40);
    vectors = vectors + 2;
    if (duty_out !== 7'd3) begin
      miscompares = miscompares + 1;
      $display("FAIL ramp2_final: got %0d, required 3", duty_out);
    end
    if (busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL ramp2_busy_end: got %0b, required 0", busy);
    end
  endtask

  task automatic test_clamp;
    int e;
    write_reg(2'd1, 32'd1, e);
    write_reg(2'd0, 32'd127, e);
    for (int k = 1; k <= 97; k++) push_exp(e + k * (TICK + 2), 3 + k);
    ADDR = 2'd0;
    #1;
    vectors = vectors + 1;
    if (RD !== 32'd100) begin
      miscompares = miscompares + 1;
      $display("FAIL clamp_target_rd: got %0d, required 100", RD);
    end
    wait_until(e + 97 * (TICK + 2) + 20);
    vectors = vectors + 2;
    if (duty_out !== 7'd100) begin
      miscompares = miscompares + 1;
      $display("FAIL clamp_final: got %0d, required 100", duty_out);
    end
    if (busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL clamp_busy: got %0b, required 0", busy);
    end
  endtask

  task automatic test_reverse;
    int e;
    int s;
    write_reg(2'd1, 32'd0, e);
    write_reg(2'd0, 32'd0, e);
    push_exp(e + 1, 0);
    wait_until(e + 3);
    write_reg(2'd1, 32'd1, e);
    write_reg(2'd0, 32'd50, e);
    for (int k = 1; k <= 10; k++) push_exp(e + k * (TICK + 2), k);
    wait_until(e + 10 * (TICK + 2));
    s = cyc;
    write_reg(2'd0, 32'd5, e);
    for (int j = 1; j <= 5; j++) push_exp(s + j * (TICK + 2), 10 - j);
    wait_until(s + 5 * (TICK + 2) + 20);
    ADDR = 2'd0;
    #1;
    vectors = vectors + 3;
    if (duty_out !== 7'd5) begin
      miscompares = miscompares + 1;
      $display("FAIL reverse_final: got %0d, required 5", duty_out);
    end
    if (RD !== 32'd5) begin
      miscompares = miscompares + 1;
      $display("FAIL reverse_target_rd: got %0d, required 5", RD);
    end
    if (busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL reverse_busy: got %0b, required 0", busy);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int e;
    write_reg(2'd1, 32'd2, e);
    write_reg(2'd0, 32'd20, e);
    wait_until(e + 4);
    #2;
    rst = 1'b1;
    ADDR = 2'd2;
    #1;
    vectors = vectors + 4;
    if (duty_out !== 7'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL rstmid_duty: got %0d, required 0", duty_out);
    end
    if (duty_we !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL rstmid_duty_we: got %0b, required 0", duty_we);
    end
    if (busy !== 1'b0) begin
      miscompares = miscompares + 1;
      $display("FAIL rstmid_busy: got %0b, required 0", busy);
    end
    if (RD !== 32'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL rstmid_current_rd: got %0d, required 0", RD);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    ADDR = 2'd0;
    #1;
    vectors = vectors + 2;
    if (duty_out !== 7'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL rstmid_idle_duty: got %0d, required 0", duty_out);
    end
    if (RD !== 32'd0) begin
      miscompares = miscompares + 1;
      $display("FAIL rstmid_target_rd: got %0d, required 0", RD);
    end
    @(negedge clk);
    write_reg(2'd0, 32'd2, e);
    push_exp(e + 1, 2);
    wait_until(e + 5);
  endtask

  initial begin
    rst  = 1'b1;
    WE   = 1'b0;
    ADDR = 2'd0;
    WD   = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset;
    test_jump;
    test_ramp_rate2;
    test_clamp;
    test_reverse;
    test_reset_mid;
    vectors = vectors + 1;
    if (exp_q.size() != 0) begin
      miscompares = miscompares + 1;
      $display("FAIL missing_pulses: got %0d outstanding, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
